// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port byte-write-enable data RAM.
// Round-robin grant, store lane placement, one-cycle load return with extension.
module dmem_arbiter #(
    parameter int unsigned AWIDTH = 14,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_p0_valid,
    output logic              o_p0_ready,
    input  logic              i_p0_we,
    input  logic [31:0]       i_p0_addr,
    input  logic [1:0]        i_p0_size,
    input  logic              i_p0_unsigned,
    input  logic [DWIDTH-1:0] i_p0_wdata,
    output logic              o_p0_rsp_valid,
    output logic [DWIDTH-1:0] o_p0_rsp_rdata,
    output logic              o_p0_rsp_err,

    input  logic              i_p1_valid,
    output logic              o_p1_ready,
    input  logic              i_p1_we,
    input  logic [31:0]       i_p1_addr,
    input  logic [1:0]        i_p1_size,
    input  logic              i_p1_unsigned,
    input  logic [DWIDTH-1:0] i_p1_wdata,
    output logic              o_p1_rsp_valid,
    output logic [DWIDTH-1:0] o_p1_rsp_rdata,
    output logic              o_p1_rsp_err,

    output logic [AWIDTH-1:0] o_ram_addr,
    output logic [DWIDTH-1:0] o_ram_d,
    output logic [3:0]        o_ram_wbe,
    output logic              o_ram_en,
    input  logic [DWIDTH-1:0] i_ram_q,

    output logic [7:0]        o_err_count
);

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;
    localparam logic [1:0] SizeBad  = 2'd3;

    // Last-grant pointer: 0 = port 0 granted last, 1 = port 1 granted last.
    logic              r_last;

    logic              r_rsp_vld;
    logic              r_rsp_port;
    logic              r_rsp_we;
    logic [1:0]        r_rsp_size;
    logic              r_rsp_uns;
    logic [1:0]        r_rsp_off;
    logic              r_rsp_err;
    logic [7:0]        r_err_count;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_gnt;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [DWIDTH-1:0] w_wdata;
    logic              w_misalign;
    logic              w_range_err;
    logic              w_err;
    logic              w_access;
    logic [3:0]        w_wbe_raw;
    logic [DWIDTH-1:0] w_wdat_rep;
    logic [DWIDTH-1:0] w_lane;
    logic [DWIDTH-1:0] w_ld;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    assign w_gnt0 = rst_n & i_p0_valid & (~i_p1_valid | r_last);
    assign w_gnt1 = rst_n & i_p1_valid & (~i_p0_valid | ~r_last);
    assign w_gnt  = w_gnt0 | w_gnt1;

    assign o_p0_ready = w_gnt0;
    assign o_p1_ready = w_gnt1;

    always_comb begin
        w_we    = i_p0_we;
        w_addr  = i_p0_addr;
        w_size  = i_p0_size;
        w_uns   = i_p0_unsigned;
        w_wdata = i_p0_wdata;
        if (w_gnt1) begin
            w_we    = i_p1_we;
            w_addr  = i_p1_addr;
            w_size  = i_p1_size;
            w_uns   = i_p1_unsigned;
            w_wdata = i_p1_wdata;
        end
    end

    always_comb begin
        w_misalign = 1'b0;
        case (w_size)
            SizeHalf: w_misalign = w_addr[0];
            SizeWord: w_misalign = |w_addr[1:0];
            SizeBad:  w_misalign = 1'b1;
            default:  w_misalign = 1'b0;
        endcase
    end

    assign w_range_err = |w_addr[31:AWIDTH+2];
    assign w_err       = w_misalign | w_range_err;
    assign w_access    = w_gnt & ~w_err;

    always_comb begin
        w_wbe_raw  = 4'b0000;
        w_wdat_rep = w_wdata;
        case (w_size)
            SizeByte: begin
                w_wbe_raw  = 4'b0001 << w_addr[1:0];
                w_wdat_rep = {4{w_wdata[7:0]}};
            end
            SizeHalf: begin
                w_wbe_raw  = 4'b0011 << w_addr[1:0];
                w_wdat_rep = {2{w_wdata[15:0]}};
            end
            SizeWord: begin
                w_wbe_raw  = 4'b1111;
                w_wdat_rep = w_wdata;
            end
            default: begin
                w_wbe_raw  = 4'b0000;
                w_wdat_rep = w_wdata;
            end
        endcase
    end

    assign o_ram_en   = w_access;
    assign o_ram_addr = w_addr[AWIDTH+1:2];
    assign o_ram_d    = w_wdat_rep;
    assign o_ram_wbe  = (w_access & w_we) ? w_wbe_raw : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_rsp_vld  <= 1'b0;
            r_rsp_port <= 1'b0;
            r_rsp_we   <= 1'b0;
            r_rsp_size <= 2'd0;
            r_rsp_uns  <= 1'b0;
            r_rsp_off  <= 2'd0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_vld <= w_gnt;
            if (w_gnt) begin
                r_last     <= w_gnt1;
                r_rsp_port <= w_gnt1;
                r_rsp_we   <= w_we;
                r_rsp_size <= w_size;
                r_rsp_uns  <= w_uns;
                r_rsp_off  <= w_addr[1:0];
                r_rsp_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
        end else if (w_gnt && w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_err_count = r_err_count;

    always_comb begin
        w_lane = i_ram_q >> {r_rsp_off, 3'b000};
        w_ld   = '0;
        case (r_rsp_size)
            SizeByte: w_ld = {{24{~r_rsp_uns & w_lane[7]}}, w_lane[7:0]};
            SizeHalf: w_ld = {{16{~r_rsp_uns & w_lane[15]}}, w_lane[15:0]};
            default:  w_ld = w_lane;
        endcase
        if (r_rsp_we || r_rsp_err) begin
            w_ld = '0;
        end
    end

    assign o_p0_rsp_valid = r_rsp_vld & ~r_rsp_port;
    assign o_p1_rsp_valid = r_rsp_vld & r_rsp_port;
    assign o_p0_rsp_err   = o_p0_rsp_valid & r_rsp_err;
    assign o_p1_rsp_err   = o_p1_rsp_valid & r_rsp_err;
    assign o_p0_rsp_rdata = o_p0_rsp_valid ? w_ld : '0;
    assign o_p1_rsp_rdata = o_p1_rsp_valid ? w_ld : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array reference model, queued
// expected responses, and a negedge monitor that pops and compares.
module tb_dmem_arbiter;

    localparam int unsigned AW = 14;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          cyc;
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    req_t rq0;
    req_t rq1;

    logic          p0_ready, p1_ready;
    logic          p0_rsp_valid, p1_rsp_valid;
    logic [31:0]   p0_rsp_rdata, p1_rsp_rdata;
    logic          p0_rsp_err, p1_rsp_err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_d;
    logic [3:0]    ram_wbe;
    logic          ram_en;
    logic [31:0]   ram_q;
    logic [7:0]    err_count;

    dmem_arbiter #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_p0_valid     (rq0.v),
        .o_p0_ready     (p0_ready),
        .i_p0_we        (rq0.we),
        .i_p0_addr      (rq0.addr),
        .i_p0_size      (rq0.size),
        .i_p0_unsigned  (rq0.uns),
        .i_p0_wdata     (rq0.wdata),
        .o_p0_rsp_valid (p0_rsp_valid),
        .o_p0_rsp_rdata (p0_rsp_rdata),
        .o_p0_rsp_err   (p0_rsp_err),
        .i_p1_valid     (rq1.v),
        .o_p1_ready     (p1_ready),
        .i_p1_we        (rq1.we),
        .i_p1_addr      (rq1.addr),
        .i_p1_size      (rq1.size),
        .i_p1_unsigned  (rq1.uns),
        .i_p1_wdata     (rq1.wdata),
        .o_p1_rsp_valid (p1_rsp_valid),
        .o_p1_rsp_rdata (p1_rsp_rdata),
        .o_p1_rsp_err   (p1_rsp_err),
        .o_ram_addr     (ram_addr),
        .o_ram_d        (ram_d),
        .o_ram_wbe      (ram_wbe),
        .o_ram_en       (ram_en),
        .i_ram_q        (ram_q),
        .o_err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural RAM attached to the DUT: registered read, byte-enabled write.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_q <= ram[ram_addr];
            for (int i = 0; i < 4; i++) begin
                if (ram_wbe[i]) ram[ram_addr][8*i +: 8] <= ram_d[8*i +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    bit [7:0] ref_mem [int unsigned];
    int       last_g = 1;
    int       ecnt = 0;
    exp_t     exp_q[$];
    int       n_checks = 0;
    int       n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] rbyte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic bit req_err(input req_t r);
        int unsigned nb;
        if (r.size == 2'd3) return 1'b1;
        if (r.addr >= 32'(1 << (AW + 2))) return 1'b1;
        nb = 1 << r.size;
        return (r.addr % nb) != 0;
    endfunction

    function automatic req_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd);
        req_t r;
        r.v = 1'b1; r.we = we; r.addr = addr; r.size = size; r.uns = uns; r.wdata = wd;
        return r;
    endfunction

    function automatic req_t idle();
        req_t r;
        r.v = 1'b0; r.we = 1'b0; r.addr = '0; r.size = 2'd0; r.uns = 1'b0; r.wdata = '0;
        return r;
    endfunction

    function automatic req_t rnd();
        req_t r;
        r.v     = ($urandom_range(0, 3) != 0);
        r.we    = 1'($urandom_range(0, 1));
        r.uns   = 1'($urandom_range(0, 1));
        r.wdata = $urandom;
        r.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r.addr  = 32'($urandom_range(0, 127));
        if ($urandom_range(0, 19) == 0) r.addr = 32'h0000_FFF0 | (r.addr & 32'hF);
        if ($urandom_range(0, 3) != 0 && r.size != 2'd3)
            r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
        if ($urandom_range(0, 19) == 0) r.addr = r.addr | (32'h0001_0000 << $urandom_range(0, 15));
        return r;
    endfunction

    // Drive one cycle's requests, check the combinational side, and queue the response.
    task automatic issue(input req_t a, input req_t b);
        int          g;
        int          nb;
        int unsigned off;
        req_t        r;
        exp_t        e;
        logic [3:0]  wbe;
        logic [31:0] d;
        logic [63:0] val;
        rq0 = a;
        rq1 = b;
        #1;
        g = -1;
        if (rst_n) begin
            if (a.v && b.v) g = (last_g == 1) ? 0 : 1;
            else if (a.v)   g = 0;
            else if (b.v)   g = 1;
        end
        chk("p0_ready", 32'(p0_ready), 32'(g == 0));
        chk("p1_ready", 32'(p1_ready), 32'(g == 1));
        if (g < 0) begin
            chk("ram_en_nogrant", 32'(ram_en), 32'd0);
            return;
        end
        r = (g == 0) ? a : b;
        last_g = g;
        e.cyc = cyc + 1;
        e.port = g;
        e.err = req_err(r);
        e.rdata = '0;
        if (e.err) begin
            chk("ram_en_err", 32'(ram_en), 32'd0);
            chk("ram_wbe_err", 32'(ram_wbe), 32'd0);
            if (ecnt < 255) ecnt++;
        end else begin
            nb = 1 << r.size;
            off = r.addr % 4;
            chk("ram_en", 32'(ram_en), 32'd1);
            chk("ram_addr", 32'(ram_addr), r.addr / 4);
            if (r.we) begin
                wbe = '0;
                d = '0;
                for (int k = 0; k < nb; k++) wbe[off + k] = 1'b1;
                for (int i = 0; i < 4; i++) d[8*i +: 8] = r.wdata[8*(i % nb) +: 8];
                chk("ram_wbe_st", 32'(ram_wbe), 32'(wbe));
                chk("ram_d", ram_d, d);
                for (int k = 0; k < nb; k++) ref_mem[r.addr + k] = r.wdata[8*k +: 8];
            end else begin
                chk("ram_wbe_ld", 32'(ram_wbe), 32'd0);
                val = '0;
                for (int k = 0; k < nb; k++) val = val | (64'(rbyte(r.addr + k)) << (8 * k));
                if (!r.uns && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
                e.rdata = val[31:0];
            end
        end
        e.ecnt = ecnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every cycle, the response pulse pattern must match the queue head.
    always @(negedge clk) begin
        logic [1:0] ev;
        exp_t       e;
        ev = 2'b00;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) ev = (exp_q[0].port == 1) ? 2'b10 : 2'b01;
        chk("rsp_valid", {30'd0, p1_rsp_valid, p0_rsp_valid}, {30'd0, ev});
        if (ev != 2'b00) begin
            e = exp_q.pop_front();
            if (e.port == 0) begin
                chk("p0_rsp_err", 32'(p0_rsp_err), 32'(e.err));
                chk("p0_rsp_rdata", p0_rsp_rdata, e.rdata);
            end else begin
                chk("p1_rsp_err", 32'(p1_rsp_err), 32'(e.err));
                chk("p1_rsp_rdata", p1_rsp_rdata, e.rdata);
            end
            chk("err_count", 32'(err_count), 32'(e.ecnt));
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram_q = '0;
        rq0 = idle();
        rq1 = idle();
        @(negedge clk);

        // Held in reset: nothing granted, RAM idle.
        issue(mk(0, 32'h0, 2'd2, 0, 0), mk(0, 32'h4, 2'd2, 0, 0));
        chk("err_count_reset", 32'(err_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // Contention straight after reset: p0, p1, p0, p1.
        for (int i = 0; i < 4; i++) begin
            issue(mk(0, 32'h20, 2'd2, 0, 0), mk(0, 32'h24, 2'd2, 0, 0));
            tick();
        end

        issue(mk(1, 32'h10, 2'd2, 0, 32'hDEADBEEF), idle()); tick();
        issue(mk(0, 32'h10, 2'd2, 0, 0), idle()); tick();

        issue(mk(1, 32'h13, 2'd0, 0, 32'h000000A5), idle()); tick();
        issue(mk(0, 32'h13, 2'd0, 0, 0), idle()); tick();
        issue(mk(0, 32'h13, 2'd0, 1, 0), idle()); tick();
        issue(mk(1, 32'h12, 2'd1, 0, 32'h00008001), idle()); tick();
        issue(mk(0, 32'h12, 2'd1, 0, 0), idle()); tick();
        issue(mk(0, 32'h12, 2'd1, 1, 0), idle()); tick();

        issue(mk(0, 32'h11, 2'd2, 0, 0), idle()); tick();
        issue(mk(0, 32'h01, 2'd1, 0, 0), idle()); tick();
        issue(mk(1, 32'h00, 2'd3, 0, 32'h1234), idle()); tick();
        issue(mk(0, 32'h0001_0000, 2'd2, 0, 0), idle()); tick();

        // Fill 8 words, then p1 streams them back-to-back.
        for (int k = 0; k < 8; k++) begin
            issue(mk(1, 32'h40 + 32'(4 * k), 2'd2, 0, 32'hA000_0000 + 32'(k * 32'h0101)), idle());
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            issue(idle(), mk(0, 32'h40 + 32'(4 * k), 2'd2, 0, 0));
            tick();
        end

        for (int i = 0; i < 600; i++) begin
            issue(rnd(), rnd());
            tick();
        end

        // Reset arrives before the load's response can be registered.
        issue(mk(0, 32'h10, 2'd2, 0, 0), idle());
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        last_g = 1;
        ecnt = 0;
        tick();
        issue(mk(0, 32'h10, 2'd2, 0, 0), mk(0, 32'h14, 2'd2, 0, 0));
        chk("err_count_midreset", 32'(err_count), 32'd0);
        tick();
        rst_n = 1'b1;
        issue(mk(0, 32'h10, 2'd2, 0, 0), mk(0, 32'h14, 2'd2, 0, 0)); tick();
        issue(idle(), idle()); tick();

        for (int i = 0; i < 300; i++) begin
            issue(mk(0, 32'h0, 2'd3, 0, 0), idle());
            tick();
        end
        issue(idle(), idle()); tick();
        issue(idle(), idle()); tick();
        chk("err_count_sat", 32'(err_count), 32'd255);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
